memory_access_cycle: RTL and testbench

//  MEM pipeline stage between the EX/MEM boundary and writeBack_cycle. Issues loads/stores to data memory

---
 rtl/memory_access_cycle.sv | 185 ++++++++++++++++++
 tb/tb_memory_access_cycle.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_cycle.sv
// MEM pipeline stage: issues data-memory loads/stores with a busywait handshake,
// aligns store lanes and load data, and registers the MEM/WB boundary.
module memory_access_cycle #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteE,
  input  logic        JtypeE,
  input  logic        MemReadE,
  input  logic        MemWriteE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] StoreDataE,
  input  logic [5:0]  ALUSelectE,
  input  logic [4:0]  WriteAddressE,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait,
  output logic        StallM,
  output logic        RegWriteM,
  output logic        JtypeM,
  output logic        MemReadM,
  output logic [5:0]  ALUSelectM,
  output logic [4:0]  WriteAddressM,
  output logic [31:0] ALUOutM,
  output logic [31:0] DataMemOutM,
  output logic        MisalignM,
  output logic        MemErrorM
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  typedef struct packed {
    logic        regwrite;
    logic        jtype;
    logic        memread;
    logic [5:0]  alusel;
    logic [4:0]  wraddr;
    logic [31:0] aluout;
    logic [31:0] data;
    logic        misalign;
    logic        memerr;
  } mw_t;

  localparam int unsigned CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LIMIT_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] LIMIT = LIMIT_I[CW-1:0];

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    off_q;
  logic          load_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  mw_t           mw;

  logic [1:0]  off;
  logic [1:0]  size;
  logic        mem_op;
  logic        aligned;
  logic        access;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        timeout_hit;
  mw_t         mw_e;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    off     = ALUOutE[1:0];
    size    = ALUSelectE[1:0];
    mem_op  = MemReadE | MemWriteE;
    aligned = 1'b0;
    case (size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      default: aligned = (off == 2'b00);
    endcase
    access = mem_op & aligned;
    be     = 4'b0000;
    if (!MemReadE) begin
      case (size)
        2'b00:   be = 4'b0001 << off;
        2'b01:   be = 4'b0011 << off;
        default: be = 4'b1111;
      endcase
    end
    wdata = StoreDataE << {off, 3'b000};

    mw_e          = '0;
    mw_e.regwrite = RegWriteE;
    mw_e.jtype    = JtypeE;
    mw_e.memread  = MemReadE;
    mw_e.alusel   = ALUSelectE;
    mw_e.wraddr   = WriteAddressE;
    mw_e.aluout   = ALUOutE;
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == LIMIT);
  assign StallM      = (state == REQ) || ((state == IDLE) && access);

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous, active-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      off_q          <= '0;
      load_q         <= 1'b0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      mw             <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            mem_read       <= MemReadE;
            mem_write      <= ~MemReadE;
            mem_address    <= {ALUOutE[31:2], 2'b00};
            mem_writedata  <= wdata;
            mem_byteenable <= be;
            off_q          <= off;
            load_q         <= MemReadE;
            wait_cnt       <= '0;
            mw             <= '0;
            state          <= REQ;
          end else begin
            // A misaligned memory op passes through as a flagged, non-writing instruction.
            mw          <= mw_e;
            mw.regwrite <= RegWriteE & ~mem_op;
            mw.misalign <= mem_op;
          end
        end
        REQ: begin
          mw <= '0;
          if (!mem_busywait) begin
            rdata_q   <= load_q ? (mem_readdata >> {off_q, 3'b000}) : 32'h0;
            err_q     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end else if (timeout_hit) begin
            rdata_q   <= 32'h0;
            err_q     <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          mw          <= mw_e;
          mw.regwrite <= RegWriteE & ~err_q;
          mw.data     <= rdata_q;
          mw.memerr   <= err_q;
          wait_cnt    <= '0;
          state       <= IDLE;
        end
        default: begin
          mw    <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign RegWriteM     = mw.regwrite;
  assign JtypeM        = mw.jtype;
  assign MemReadM      = mw.memread;
  assign ALUSelectM    = mw.alusel;
  assign WriteAddressM = mw.wraddr;
  assign ALUOutM       = mw.aluout;
  assign DataMemOutM   = mw.data;
  assign MisalignM     = mw.misalign;
  assign MemErrorM     = mw.memerr;

endmodule

// File: tb/tb_memory_access_cycle.sv
// Bench for memory_access_cycle: directed vector table, random instruction stream
// against a transaction-level model, and a reset-during-request sequence.
module tb_memory_access_cycle;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWriteE, JtypeE, MemReadE, MemWriteE;
  logic [31:0] ALUOutE, StoreDataE;
  logic [5:0]  ALUSelectE;
  logic [4:0]  WriteAddressE;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
  logic        StallM, RegWriteM, JtypeM, MemReadM, MisalignM, MemErrorM;
  logic [5:0]  ALUSelectM;
  logic [4:0]  WriteAddressM;
  logic [31:0] ALUOutM, DataMemOutM;

  memory_access_cycle #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .JtypeE(JtypeE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .ALUOutE(ALUOutE), .StoreDataE(StoreDataE), .ALUSelectE(ALUSelectE),
    .WriteAddressE(WriteAddressE),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .StallM(StallM), .RegWriteM(RegWriteM), .JtypeM(JtypeM), .MemReadM(MemReadM),
    .ALUSelectM(ALUSelectM), .WriteAddressM(WriteAddressM), .ALUOutM(ALUOutM),
    .DataMemOutM(DataMemOutM), .MisalignM(MisalignM), .MemErrorM(MemErrorM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        regw, jtype, mrd, mwr;
    logic [31:0] alu, sd;
    logic [5:0]  sel;
    logic [4:0]  rd_addr;
    int          lat;
    logic [31:0] rdata;
    int          exp_stall;
    logic        exp_regw, exp_mis, exp_err;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic vec_t mk(input logic regw, input logic jtype, input logic mrd, input logic mwr,
                              input logic [31:0] alu, input logic [31:0] sd, input logic [5:0] sel,
                              input logic [4:0] rd_addr, input int lat, input logic [31:0] rdata);
    vec_t v;
    v.regw = regw; v.jtype = jtype; v.mrd = mrd; v.mwr = mwr;
    v.alu = alu; v.sd = sd; v.sel = sel; v.rd_addr = rd_addr;
    v.lat = lat; v.rdata = rdata;
    v.exp_stall = 0; v.exp_regw = regw; v.exp_mis = 1'b0; v.exp_err = 1'b0;
    v.exp_data = 32'h0; v.exp_be = 4'h0; v.exp_wdata = 32'h0;
    return v;
  endfunction

  function automatic vec_t with_exp(input vec_t v, input int st, input logic rw, input logic mis,
                                    input logic err, input logic [31:0] data, input logic [3:0] be,
                                    input logic [31:0] wdata);
    v.exp_stall = st; v.exp_regw = rw; v.exp_mis = mis; v.exp_err = err;
    v.exp_data = data; v.exp_be = be; v.exp_wdata = wdata;
    return v;
  endfunction

  // Transaction-level reference: size in bytes, offset, latency -> outcome.
  function automatic vec_t model(input vec_t v);
    int bytes = 1 << v.sel[1:0];
    int off   = int'(v.alu[1:0]);
    bit mem   = v.mrd | v.mwr;
    v.exp_data = 32'h0; v.exp_be = 4'h0; v.exp_mis = 1'b0; v.exp_err = 1'b0;
    v.exp_regw = v.regw; v.exp_stall = 0;
    v.exp_wdata = v.sd << (8 * off);
    if (mem && (off % bytes) != 0) begin
      v.exp_mis = 1'b1; v.exp_regw = 1'b0;
    end else if (mem) begin
      if (v.lat >= TMO) begin
        v.exp_err = 1'b1; v.exp_regw = 1'b0; v.exp_stall = TMO + 1;
      end else begin
        v.exp_stall = v.lat + 2;
        if (v.mrd) v.exp_data = v.rdata >> (8 * off);
      end
      if (!v.mrd) v.exp_be = 4'(((1 << bytes) - 1) << off);
    end
    return v;
  endfunction

  // Called just after a falling edge; returns just after the falling edge that
  // follows the edge on which this instruction reached MEM/WB.
  task automatic run_vec(input vec_t v, input string tag);
    int  stalls = 0;
    int  reqs = 0;
    bit  stall;
    bit  done = 0;
    bit  is_store = v.mwr & ~v.mrd;
    RegWriteE = v.regw; JtypeE = v.jtype; MemReadE = v.mrd; MemWriteE = v.mwr;
    ALUOutE = v.alu; StoreDataE = v.sd; ALUSelectE = v.sel; WriteAddressE = v.rd_addr;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (mem_read || mem_write) begin
        reqs++;
        if (reqs == 1) begin
          check1({tag, ".mem_read"}, mem_read, v.mrd);
          check1({tag, ".mem_write"}, mem_write, is_store);
          check({tag, ".address"}, mem_address, {v.alu[31:2], 2'b00});
          check({tag, ".byteenable"}, 32'(mem_byteenable), 32'(v.exp_be));
          if (is_store) check({tag, ".writedata"}, mem_writedata, v.exp_wdata);
        end
        mem_busywait = (reqs <= v.lat);
        mem_readdata = mem_busywait ? $urandom : v.rdata;
      end else begin
        mem_busywait = 1'($urandom_range(0, 1));
        mem_readdata = $urandom;
      end
      #1;
      stall = StallM;
      if (stall) stalls++;
      @(negedge clk);
      if (stall) check({tag, ".bubble"}, 32'({RegWriteM, JtypeM, MemReadM, MisalignM, MemErrorM}), 32'h0);
      else done = 1;
    end
    if (!done) check1({tag, ".stall_bound"}, 1'b0, 1'b1);
    check({tag, ".stall_cycles"}, stalls, v.exp_stall);
    check({tag, ".req_cycles"}, reqs, (v.exp_stall == 0) ? 0 : v.exp_stall - 1);
    check1({tag, ".RegWriteM"}, RegWriteM, v.exp_regw);
    check1({tag, ".JtypeM"}, JtypeM, v.jtype);
    check1({tag, ".MemReadM"}, MemReadM, v.mrd);
    check({tag, ".ALUOutM"}, ALUOutM, v.alu);
    check({tag, ".WriteAddressM"}, 32'(WriteAddressM), 32'(v.rd_addr));
    check({tag, ".ALUSelectM"}, 32'(ALUSelectM), 32'(v.sel));
    check({tag, ".DataMemOutM"}, DataMemOutM, v.exp_data);
    check1({tag, ".MisalignM"}, MisalignM, v.exp_mis);
    check1({tag, ".MemErrorM"}, MemErrorM, v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    vec_t v;
    int   kind;

    RegWriteE = 0; JtypeE = 0; MemReadE = 0; MemWriteE = 0;
    ALUOutE = 0; StoreDataE = 0; ALUSelectE = 0; WriteAddressE = 0;
    mem_readdata = 0; mem_busywait = 0;

    tbl[0]  = with_exp(mk(1,0,0,0, 32'h1234, 0, 6'h00, 5, 0, 0), 0, 1, 0, 0, 0, 4'h0, 0);
    tbl[1]  = with_exp(mk(1,0,1,0, 32'h100, 0, 6'h02, 7, 2, 32'hDEADBEEF), 4, 1, 0, 0, 32'hDEADBEEF, 4'h0, 0);
    tbl[2]  = with_exp(mk(0,0,0,1, 32'h103, 32'hAB, 6'h00, 0, 1, 0), 3, 0, 0, 0, 0, 4'b1000, 32'hAB000000);
    tbl[3]  = with_exp(mk(0,0,0,1, 32'h102, 32'h55, 6'h02, 0, 0, 0), 0, 0, 1, 0, 0, 4'h0, 0);
    tbl[4]  = with_exp(mk(1,0,1,0, 32'h102, 0, 6'h02, 9, 0, 0), 0, 0, 1, 0, 0, 4'h0, 0);
    tbl[5]  = with_exp(mk(1,0,1,0, 32'h200, 0, 6'h02, 3, 10, 32'h0BADF00D), 5, 0, 0, 1, 0, 4'h0, 0);
    tbl[6]  = with_exp(mk(1,0,1,0, 32'h102, 0, 6'h01, 4, 0, 32'h12345678), 2, 1, 0, 0, 32'h00001234, 4'h0, 0);
    tbl[7]  = with_exp(mk(1,0,1,0, 32'h101, 0, 6'h04, 6, 1, 32'h12345678), 3, 1, 0, 0, 32'h00123456, 4'h0, 0);
    tbl[8]  = with_exp(mk(0,0,0,1, 32'h102, 32'h1234BEEF, 6'h01, 0, 0, 0), 2, 0, 0, 0, 0, 4'b1100, 32'hBEEF0000);
    tbl[9]  = with_exp(mk(1,1,0,0, 32'h40, 0, 6'h00, 1, 0, 0), 0, 1, 0, 0, 0, 4'h0, 0);
    tbl[10] = with_exp(mk(1,0,1,1, 32'h104, 32'h77, 6'h02, 8, 0, 32'hCAFEF00D), 2, 1, 0, 0, 32'hCAFEF00D, 4'h0, 0);
    tbl[11] = with_exp(mk(1,0,1,0, 32'h101, 0, 6'h01, 2, 0, 0), 0, 0, 1, 0, 0, 4'h0, 0);
    tbl[12] = with_exp(mk(0,0,0,1, 32'h10, 32'h11223344, 6'h02, 0, 3, 0), 5, 0, 0, 0, 0, 4'b1111, 32'h11223344);

    // Reset state
    #2;
    check1("reset.StallM", StallM, 1'b0);
    check("reset.requests", 32'({mem_read, mem_write}), 32'h0);
    check("reset.flags", 32'({RegWriteM, JtypeM, MemReadM, MisalignM, MemErrorM}), 32'h0);
    check("reset.ALUOutM", ALUOutM, 32'h0);
    check("reset.DataMemOutM", DataMemOutM, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      v = mk(1'($urandom_range(0, 1)), 0, 0, 0, $urandom, $urandom, 6'($urandom_range(0, 63)),
             5'($urandom_range(0, 31)), int'($urandom_range(0, 5)), $urandom);
      case (kind)
        1: begin v.mrd = 1; v.sel[2:0] = 3'(($urandom_range(0, 4) == 3) ? 2 : $urandom_range(0, 2) + 4 * $urandom_range(0, 1)); end
        2: begin v.mwr = 1; v.sel[2:0] = 3'($urandom_range(0, 2)); end
        3: v.jtype = 1;
        default: ;
      endcase
      if (v.mrd || v.mwr) v.alu[31:12] = '0;
      run_vec(model(v), $sformatf("rnd%0d", i));
    end

    // Reset while a load is waiting on memory
    v = mk(1, 0, 1, 0, 32'h300, 0, 6'h02, 3, 20, 0);
    RegWriteE = v.regw; JtypeE = 0; MemReadE = 1; MemWriteE = 0;
    ALUOutE = v.alu; StoreDataE = 0; ALUSelectE = v.sel; WriteAddressE = v.rd_addr;
    mem_busywait = 1'b1;
    repeat (2) @(negedge clk);
    check1("rstreq.in_req", mem_read, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("rstreq.requests", 32'({mem_read, mem_write}), 32'h0);
    check("rstreq.flags", 32'({RegWriteM, JtypeM, MemReadM, MisalignM, MemErrorM}), 32'h0);
    check("rstreq.ALUOutM", ALUOutM, 32'h0);
    check("rstreq.DataMemOutM", DataMemOutM, 32'h0);
    MemReadE = 0; RegWriteE = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check1("rstreq.idle_stall", StallM, 1'b0);
    @(negedge clk);
    run_vec(with_exp(mk(1,0,1,0, 32'h300, 0, 6'h02, 3, 3, 32'h600DCAFE), 5, 1, 0, 0, 32'h600DCAFE, 4'h0, 0), "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
